// File: rtl/frac_pkg.sv
// Shared definitions for the fraction reducer.
// Holds the FSM state encoding, the default operand width and the width of
// the per-bit step counter.
package frac_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV0 = 2'd1,
    S_DIV1 = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/_div_step.sv
// One iteration of an unsigned restoring divider.
// Ports:
//   i_r   - partial remainder (WIDTH+1 bits), always < i_g on entry
//   i_bit - next dividend bit, MSB first
//   i_g   - divisor
//   o_r   - partial remainder after this step
//   o_q   - quotient bit produced by this step
module _div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   i_r,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_g,
  output logic [WIDTH:0]   o_r,
  output logic             o_q
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH:0]   w_sub;
  logic             w_ge;

  assign w_shift = {i_r, i_bit};
  assign w_ge    = (w_shift >= {2'b00, i_g});
  // When w_ge is set the true difference is below g, so the modulo
  // subtraction on the low WIDTH+1 bits is exact.
  assign w_sub   = w_shift[WIDTH:0] - {1'b0, i_g};
  assign o_r     = w_ge ? w_sub : w_shift[WIDTH:0];
  assign o_q     = w_ge;

endmodule

// File: rtl/_frac_reduce.sv
// Reduces a fraction num0/num1 to lowest terms using the gcd from _gcd.
// A rising edge of _success (in IDLE or DONE) captures the operands and gcd;
// a single shared restoring divider then produces num0/g and num1/g, one
// quotient bit per clock.
// Ports:
//   _clock, _reset        - clock, async active-high reset
//   _num0/_num1/_greatest - operands and their gcd
//   _success              - gcd valid (level; rising edge triggers)
//   _red0/_red1           - reduced numerator / denominator
//   _busy/_done/_err      - division running / result valid / gcd was zero
//   _state                - current FSM state, for observation
module _frac_reduce
  import frac_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic [WIDTH-1:0] _num0,
  input  logic [WIDTH-1:0] _num1,
  input  logic [WIDTH-1:0] _greatest,
  input  logic             _success,
  output logic [WIDTH-1:0] _red0,
  output logic [WIDTH-1:0] _red1,
  output logic             _busy,
  output logic             _done,
  output logic             _err,
  output logic [1:0]       _state
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           r_state;
  logic             r_succ_prev;
  logic [WIDTH-1:0] r_n1;
  logic [WIDTH-1:0] r_g;
  logic [WIDTH-1:0] r_dvd;   // dividend, shifted left so the MSB is the next bit
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_red0;
  logic [WIDTH-1:0] r_red1;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_trig;
  logic             w_last;
  logic [WIDTH:0]   w_rem;
  logic             w_q;
  logic [WIDTH-1:0] w_quo_next;

  assign w_trig     = _success & ~r_succ_prev;
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_quo_next = {r_quo[WIDTH-2:0], w_q};

  _div_step #(.WIDTH(WIDTH)) u_step (
    .i_r   (r_rem),
    .i_bit (r_dvd[WIDTH-1]),
    .i_g   (r_g),
    .o_r   (w_rem),
    .o_q   (w_q)
  );

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      r_state     <= S_IDLE;
      r_succ_prev <= 1'b0;
      r_n1        <= '0;
      r_g         <= '0;
      r_dvd       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
      r_red0      <= '0;
      r_red1      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_succ_prev <= _success;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_trig) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (_greatest != '0) begin
              r_state <= S_DIV0;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
              r_rem   <= '0;
              r_quo   <= '0;
              r_dvd   <= _num0;
              r_n1    <= _num1;
              r_g     <= _greatest;
            end else begin
              // Divide by zero: pass the operands through and flag it.
              r_state <= S_DONE;
              r_red0  <= _num0;
              r_red1  <= _num1;
              r_err   <= 1'b1;
              r_done  <= 1'b1;
            end
          end
        end
        S_DIV0: begin
          if (w_last) begin
            r_red0  <= w_quo_next;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_dvd   <= r_n1;
            r_state <= S_DIV1;
          end else begin
            r_rem <= w_rem;
            r_quo <= w_quo_next;
            r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DIV1: begin
          if (w_last) begin
            r_red1  <= w_quo_next;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_rem <= w_rem;
            r_quo <= w_quo_next;
            r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign _red0  = r_red0;
  assign _red1  = r_red1;
  assign _busy  = r_busy;
  assign _done  = r_done;
  assign _err   = r_err;
  assign _state = r_state;

endmodule

// File: tb/tb__frac_reduce.sv
module tb__frac_reduce;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] num0;
  logic [W-1:0] num1;
  logic [W-1:0] greatest;
  logic         success;
  logic [W-1:0] red0;
  logic [W-1:0] red1;
  logic         busy;
  logic         done;
  logic         err;
  logic [1:0]   state;

  int checks   = 0;
  int failures = 0;

  // Bench-side memory of the last expected results (outputs hold them).
  logic [W-1:0] prev0 = '0;
  logic [W-1:0] prev1 = '0;

  _frac_reduce #(.WIDTH(W)) dut (
    ._clock    (clk),
    ._reset    (rst),
    ._num0     (num0),
    ._num1     (num1),
    ._greatest (greatest),
    ._success  (success),
    ._red0     (red0),
    ._red1     (red1),
    ._busy     (busy),
    ._done     (done),
    ._err      (err),
    ._state    (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive operands and raise _success; returns just after capture edge k.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] g, input bit hold);
    num0 = a; num1 = b; greatest = g; success = 1'b1;
    @(negedge clk);
    if (!hold) success = 1'b0;
  endtask

  // Full non-zero-gcd transaction with checks along the way.
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] g, input logic [W-1:0] e0,
                         input logic [W-1:0] e1, input bit hold);
    start(a, b, g, hold);
    check({tag, "_k_busy"}, 32'(busy), 32'd1);
    check({tag, "_k_done"}, 32'(done), 32'd0);
    check({tag, "_k_red0_hold"}, 32'(red0), 32'(prev0));
    check({tag, "_k_state"}, 32'(state), 32'd1);
    step(8);
    check({tag, "_k8_red0"}, 32'(red0), 32'(e0));
    check({tag, "_k8_red1_hold"}, 32'(red1), 32'(prev1));
    check({tag, "_k8_state"}, 32'(state), 32'd2);
    step(7);
    check({tag, "_k15_busy"}, 32'(busy), 32'd1);
    check({tag, "_k15_done"}, 32'(done), 32'd0);
    step(1);
    check({tag, "_k16_done"}, 32'(done), 32'd1);
    check({tag, "_k16_busy"}, 32'(busy), 32'd0);
    check({tag, "_k16_red0"}, 32'(red0), 32'(e0));
    check({tag, "_k16_red1"}, 32'(red1), 32'(e1));
    check({tag, "_k16_err"}, 32'(err), 32'd0);
    check({tag, "_k16_state"}, 32'(state), 32'd3);
    prev0 = e0;
    prev1 = e1;
  endtask

  task automatic run_err(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    start(a, b, '0, 1'b0);
    check({tag, "_err"}, 32'(err), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_red0"}, 32'(red0), 32'(a));
    check({tag, "_red1"}, 32'(red1), 32'(b));
    check({tag, "_state"}, 32'(state), 32'd3);
    prev0 = a;
    prev1 = b;
    step(1);
  endtask

  initial begin
    rst = 1'b1; num0 = '0; num1 = '0; greatest = '0; success = 1'b0;
    step(2);
    check("rst_red0", 32'(red0), 32'd0);
    check("rst_red1", 32'(red1), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    rst = 1'b0;
    step(2);

    // normal, coprime, all-max, zero dividend
    run_div("norm", 8'd36, 8'd24, 8'd12, 8'd3, 8'd2, 1'b0);
    step(1);
    run_div("copr", 8'd17, 8'd5, 8'd1, 8'd17, 8'd5, 1'b0);
    step(1);
    run_div("max", 8'd255, 8'd255, 8'd255, 8'd1, 8'd1, 1'b0);
    step(1);
    run_div("zdvd", 8'd0, 8'd24, 8'd24, 8'd0, 8'd1, 1'b0);
    step(1);

    // divide by zero
    run_err("gz0", 8'd0, 8'd0);
    run_err("gz7", 8'd7, 8'd9);
    // a normal capture after an error clears err
    run_div("after_err", 8'd200, 8'd150, 8'd50, 8'd4, 8'd3, 1'b0);
    step(1);

    // held _success: one capture, no retrigger
    run_div("held", 8'd100, 8'd75, 8'd25, 8'd4, 8'd3, 1'b1);
    step(24);
    check("held_busy", 32'(busy), 32'd0);
    check("held_done", 32'(done), 32'd1);
    check("held_state", 32'(state), 32'd3);
    check("held_red0", 32'(red0), 32'd4);
    success = 1'b0;
    step(2);

    // second rise mid-division is ignored
    start(8'd36, 8'd24, 8'd12, 1'b0);
    step(4);
    num0 = 8'd17; num1 = 8'd5; greatest = 8'd1; success = 1'b1;
    step(1);
    check("early_busy", 32'(busy), 32'd1);
    step(11);
    check("early_done", 32'(done), 32'd1);
    check("early_red0", 32'(red0), 32'd3);
    check("early_red1", 32'(red1), 32'd2);
    success = 1'b0;
    step(2);
    prev0 = 8'd3;
    prev1 = 8'd2;

    // reset during DIV1, asserted between edges
    start(8'd100, 8'd75, 8'd25, 1'b0);
    step(11);
    check("mid_state", 32'(state), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_red0", 32'(red0), 32'd0);
    check("mid_rst_red1", 32'(red1), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_state", 32'(state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    prev0 = '0;
    prev1 = '0;
    step(1);
    run_div("post_rst", 8'd36, 8'd24, 8'd12, 8'd3, 8'd2, 1'b0);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
